vga_output: RTL and testbench

VGA_OUTPUT -- requirements
Module: vga_output

---
 rtl/vga_output_pkg.sv | 46 ++++
 rtl/vga_output_if.sv | 27 ++
 rtl/vga_timing.sv | 69 ++++++
 rtl/vga_output.sv | 77 +++++++
 tb/tb_vga_output.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/vga_output_pkg.sv
// Shared VGA constants for the video path and the game core.
// Contents: 640x480@60 timing constants and line/frame totals, 3-bit
// pixel-state object codes, 12-bit RGB palette constants, and the
// palette lookup used by the output stage.
package vga_output_pkg;

    localparam int H_DISPLAY = 640;
    localparam int H_FRONT   = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BACK    = 48;
    localparam int V_DISPLAY = 480;
    localparam int V_FRONT   = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BACK    = 33;

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    typedef logic [2:0]  pixel_state_t;
    typedef logic [11:0] rgb12_t;

    localparam pixel_state_t PIX_BACKGROUND    = 3'b000;
    localparam pixel_state_t PIX_PLAYER        = 3'b001;
    localparam pixel_state_t PIX_PLAYER_BULLET = 3'b010;
    localparam pixel_state_t PIX_ENEMY         = 3'b011;
    localparam pixel_state_t PIX_ENEMY_BULLET  = 3'b100;

    localparam rgb12_t RGB_BLACK   = 12'h000;
    localparam rgb12_t RGB_WHITE   = 12'hFFF;
    localparam rgb12_t RGB_YELLOW  = 12'hFF0;
    localparam rgb12_t RGB_RED     = 12'hF00;
    localparam rgb12_t RGB_MAGENTA = 12'hF0F;

    // Reserved codes fall through to black.
    function automatic rgb12_t palette(input pixel_state_t code);
        case (code)
            PIX_BACKGROUND:    return RGB_BLACK;
            PIX_PLAYER:        return RGB_WHITE;
            PIX_PLAYER_BULLET: return RGB_YELLOW;
            PIX_ENEMY:         return RGB_RED;
            PIX_ENEMY_BULLET:  return RGB_MAGENTA;
            default:           return RGB_BLACK;
        endcase
    endfunction

endpackage

// File: rtl/vga_output_if.sv
// Video bus between the game core side and the VGA output stage.
// Signals: i_pixelState (object code for the pixel being scanned),
// o_Red/o_Green/o_Blue (4-bit colour), o_HSync/o_VSync (active-low),
// o_Blank (high outside the visible area), o_FrameTick (frame start pulse).
// Modports: master = the VGA output stage, slave = the consumer/driver side.
interface vga_output_if;
    import vga_output_pkg::*;

    pixel_state_t i_pixelState;
    logic [3:0]   o_Red;
    logic [3:0]   o_Green;
    logic [3:0]   o_Blue;
    logic         o_HSync;
    logic         o_VSync;
    logic         o_Blank;
    logic         o_FrameTick;

    modport master (
        input  i_pixelState,
        output o_Red, o_Green, o_Blue, o_HSync, o_VSync, o_Blank, o_FrameTick
    );

    modport slave (
        output i_pixelState,
        input  o_Red, o_Green, o_Blue, o_HSync, o_VSync, o_Blank, o_FrameTick
    );
endinterface

// File: rtl/vga_timing.sv
// Horizontal/vertical scan counters plus combinational sync/blank decode.
// Ports: clk_i pixel clock, rst_i synchronous active-high reset,
// h_cnt_o/v_cnt_o current scan position, visible_o inside the active area,
// hsync_n_o/vsync_n_o active-low sync decode, frame_start_o at (0,0).
// Decode outputs are unregistered; the output stage registers them.
module vga_timing
    import vga_output_pkg::*;
#(
    parameter int H_DISPLAY = vga_output_pkg::H_DISPLAY,
    parameter int H_FRONT   = vga_output_pkg::H_FRONT,
    parameter int H_SYNC    = vga_output_pkg::H_SYNC,
    parameter int H_BACK    = vga_output_pkg::H_BACK,
    parameter int V_DISPLAY = vga_output_pkg::V_DISPLAY,
    parameter int V_FRONT   = vga_output_pkg::V_FRONT,
    parameter int V_SYNC    = vga_output_pkg::V_SYNC,
    parameter int V_BACK    = vga_output_pkg::V_BACK
) (
    input  logic       clk_i,
    input  logic       rst_i,
    output logic [9:0] h_cnt_o,
    output logic [9:0] v_cnt_o,
    output logic       visible_o,
    output logic       hsync_n_o,
    output logic       vsync_n_o,
    output logic       frame_start_o
);

    localparam int H_TOT = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOT = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST   = 10'(H_TOT - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOT - 1);
    localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
    localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
    localparam logic [9:0] HS_START = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(V_DISPLAY + V_FRONT + V_SYNC);

    logic [9:0] h_cnt_q, h_cnt_d;
    logic [9:0] v_cnt_q, v_cnt_d;

    always_comb begin
        h_cnt_d = h_cnt_q + 10'd1;
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 10'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    assign h_cnt_o       = h_cnt_q;
    assign v_cnt_o       = v_cnt_q;
    assign visible_o     = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
    assign hsync_n_o     = !((h_cnt_q >= HS_START) && (h_cnt_q < HS_END));
    assign vsync_n_o     = !((v_cnt_q >= VS_START) && (v_cnt_q < VS_END));
    assign frame_start_o = (h_cnt_q == '0) && (v_cnt_q == '0);

endmodule

// File: rtl/vga_output.sv
// VGA output stage: scan timing, palette lookup and output registers.
// Ports: i_Clk pixel clock (shared with the game core scan), i_Rst
// synchronous active-high reset, vga (master modport) carrying the pixel
// state in and the registered colour/sync/blank/frame-tick out.
// Every output is a flop fed from the current counters and i_pixelState,
// so outputs lag the scan by exactly one cycle and nothing is combinational
// from i_pixelState to a port.
module vga_output
    import vga_output_pkg::*;
#(
    parameter int H_DISPLAY = vga_output_pkg::H_DISPLAY,
    parameter int H_FRONT   = vga_output_pkg::H_FRONT,
    parameter int H_SYNC    = vga_output_pkg::H_SYNC,
    parameter int H_BACK    = vga_output_pkg::H_BACK,
    parameter int V_DISPLAY = vga_output_pkg::V_DISPLAY,
    parameter int V_FRONT   = vga_output_pkg::V_FRONT,
    parameter int V_SYNC    = vga_output_pkg::V_SYNC,
    parameter int V_BACK    = vga_output_pkg::V_BACK
) (
    input  logic          i_Clk,
    input  logic          i_Rst,
    vga_output_if.master  vga
);

    logic [9:0] h_cnt, v_cnt;
    logic       visible, hsync_n, vsync_n, frame_start;

    vga_timing #(
        .H_DISPLAY(H_DISPLAY), .H_FRONT(H_FRONT), .H_SYNC(H_SYNC), .H_BACK(H_BACK),
        .V_DISPLAY(V_DISPLAY), .V_FRONT(V_FRONT), .V_SYNC(V_SYNC), .V_BACK(V_BACK)
    ) u_timing (
        .clk_i        (i_Clk),
        .rst_i        (i_Rst),
        .h_cnt_o      (h_cnt),
        .v_cnt_o      (v_cnt),
        .visible_o    (visible),
        .hsync_n_o    (hsync_n),
        .vsync_n_o    (vsync_n),
        .frame_start_o(frame_start)
    );

    rgb12_t rgb_d, rgb_q;
    logic   hsync_q, vsync_q, blank_q, frame_tick_q;

    // Blanking overrides whatever object the core reports.
    always_comb begin
        rgb_d = RGB_BLACK;
        if (visible) begin
            rgb_d = palette(vga.i_pixelState);
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            rgb_q        <= RGB_BLACK;
            hsync_q      <= 1'b1;
            vsync_q      <= 1'b1;
            blank_q      <= 1'b1;
            frame_tick_q <= 1'b0;
        end else begin
            rgb_q        <= rgb_d;
            hsync_q      <= hsync_n;
            vsync_q      <= vsync_n;
            blank_q      <= !visible;
            frame_tick_q <= frame_start;
        end
    end

    assign vga.o_Red       = rgb_q[11:8];
    assign vga.o_Green     = rgb_q[7:4];
    assign vga.o_Blue      = rgb_q[3:0];
    assign vga.o_HSync     = hsync_q;
    assign vga.o_VSync     = vsync_q;
    assign vga.o_Blank     = blank_q;
    assign vga.o_FrameTick = frame_tick_q;

endmodule

// File: tb/tb_vga_output.sv
// Directed bench for vga_output. A default-timing instance covers line
// timing, palette and reset; a shrunken instance (15x8 totals, 120-cycle
// frame) covers frame tick periodicity and vsync width.
module tb_vga_output;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    vga_output_if vif();
    vga_output_if vif_s();

    vga_output dut (
        .i_Clk(clk),
        .i_Rst(rst),
        .vga  (vif)
    );

    vga_output #(
        .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
    ) dut_s (
        .i_Clk(clk),
        .i_Rst(rst),
        .vga  (vif_s)
    );

    logic [11:0] rgb;
    assign rgb = {vif.o_Red, vif.o_Green, vif.o_Blue};

    always #5 clk = ~clk;

    // cyc = number of non-reset edges since reset release; the outputs seen
    // after edge n reflect the scan position of cycle n-1.
    task automatic tick();
        logic r;
        r = rst;
        @(posedge clk);
        #1;
        if (r) cyc = 0;
        else   cyc++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        vif.i_pixelState   = 3'b001;
        vif_s.i_pixelState = 3'b001;
        repeat (3) tick();
        checks++; if (rgb !== 12'h000) begin errors++; $display("FAIL reset_rgb got %h exp 000", rgb); end
        checks++; if (vif.o_HSync !== 1'b1) begin errors++; $display("FAIL reset_hsync got %b exp 1", vif.o_HSync); end
        checks++; if (vif.o_VSync !== 1'b1) begin errors++; $display("FAIL reset_vsync got %b exp 1", vif.o_VSync); end
        checks++; if (vif.o_Blank !== 1'b1) begin errors++; $display("FAIL reset_blank got %b exp 1", vif.o_Blank); end
        checks++; if (vif.o_FrameTick !== 1'b0) begin errors++; $display("FAIL reset_tick got %b exp 0", vif.o_FrameTick); end
        checks++; if (vif_s.o_FrameTick !== 1'b0) begin errors++; $display("FAIL reset_tick_small got %b exp 0", vif_s.o_FrameTick); end
        checks++; if (vif_s.o_Blank !== 1'b1) begin errors++; $display("FAIL reset_blank_small got %b exp 1", vif_s.o_Blank); end
    endtask

    // Small instance: frame = 120 cycles, vsync low for scan cycles 75..104.
    task automatic test_frame();
        int  vs_low;
        int  vs_first;
        int  ph;
        logic exp_tick;
        logic exp_vs;
        vs_low   = 0;
        vs_first = -1;
        rst = 1'b0;
        for (int n = 0; n < 250; n++) begin
            tick();
            ph       = (cyc - 1) % 120;
            exp_tick = (cyc % 120) == 1;
            exp_vs   = !((ph >= 75) && (ph < 105));
            checks++; if (vif_s.o_FrameTick !== exp_tick) begin errors++; $display("FAIL frame_tick_small cyc %0d got %b exp %b", cyc, vif_s.o_FrameTick, exp_tick); end
            checks++; if (vif_s.o_VSync !== exp_vs) begin errors++; $display("FAIL vsync_small cyc %0d got %b exp %b", cyc, vif_s.o_VSync, exp_vs); end
            checks++; if (vif.o_FrameTick !== (cyc == 1)) begin errors++; $display("FAIL frame_tick cyc %0d got %b exp %b", cyc, vif.o_FrameTick, (cyc == 1)); end
            if (cyc == 1) begin
                checks++; if (vif.o_Blank !== 1'b0) begin errors++; $display("FAIL first_blank got %b exp 0", vif.o_Blank); end
                checks++; if (rgb !== 12'hFFF) begin errors++; $display("FAIL first_rgb got %h exp FFF", rgb); end
            end
            if (cyc <= 120 && vif_s.o_VSync === 1'b0) begin
                vs_low++;
                if (vs_first < 0) vs_first = cyc;
            end
        end
        checks++; if (vs_low !== 30) begin errors++; $display("FAIL vsync_width got %0d exp 30", vs_low); end
        checks++; if (vs_first !== 76) begin errors++; $display("FAIL vsync_first got %0d exp 76", vs_first); end
    endtask

    // One full line plus part of the next; pixel state 011 while h >= 640.
    task automatic test_line();
        int hs_cnt;
        int hs_first;
        int hs_last;
        int bl_first;
        int hp;
        hs_cnt   = 0;
        hs_first = -1;
        hs_last  = -1;
        bl_first = -1;
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        while (cyc < 1000) begin
            vif.i_pixelState = ((cyc % vga_output_pkg::H_TOTAL) >= 640) ? 3'b011 : 3'b001;
            tick();
            hp = (cyc - 1) % vga_output_pkg::H_TOTAL;
            if (hp >= 640) begin
                checks++; if (vif.o_Blank !== 1'b1) begin errors++; $display("FAIL line_blank cyc %0d got %b exp 1", cyc, vif.o_Blank); end
                checks++; if (rgb !== 12'h000) begin errors++; $display("FAIL line_rgb_blank cyc %0d got %h exp 000", cyc, rgb); end
            end else begin
                checks++; if (vif.o_Blank !== 1'b0) begin errors++; $display("FAIL line_visible cyc %0d got %b exp 0", cyc, vif.o_Blank); end
                checks++; if (rgb !== 12'hFFF) begin errors++; $display("FAIL line_rgb cyc %0d got %h exp FFF", cyc, rgb); end
            end
            checks++; if (vif.o_VSync !== 1'b1) begin errors++; $display("FAIL line_vsync cyc %0d got %b exp 1", cyc, vif.o_VSync); end
            if (vif.o_HSync === 1'b0) begin
                hs_cnt++;
                if (hs_first < 0) hs_first = cyc;
                hs_last = cyc;
            end
            if (vif.o_Blank === 1'b1 && bl_first < 0) bl_first = cyc;
        end
        vif.i_pixelState = 3'b001;
        checks++; if (hs_cnt !== 96) begin errors++; $display("FAIL hsync_width got %0d exp 96", hs_cnt); end
        checks++; if (hs_first !== 657) begin errors++; $display("FAIL hsync_first got %0d exp 657", hs_first); end
        checks++; if (hs_last !== 752) begin errors++; $display("FAIL hsync_last got %0d exp 752", hs_last); end
        checks++; if (bl_first !== 641) begin errors++; $display("FAIL blank_first got %0d exp 641", bl_first); end
    endtask

    // Codes 000..111 on pixels (10..17, 10); scan reaches (10,10) at cyc 8010.
    task automatic test_palette();
        logic [11:0] pal [8];
        pal = '{12'h000, 12'hFFF, 12'hFF0, 12'hF00, 12'hF0F, 12'h000, 12'h000, 12'h000};
        vif.i_pixelState = 3'b001;
        while (cyc < 8010) tick();
        for (int k = 0; k < 8; k++) begin
            vif.i_pixelState = 3'(k);
            tick();
            checks++; if (rgb !== pal[k]) begin errors++; $display("FAIL palette code %0d got %h exp %h", k, rgb, pal[k]); end
            checks++; if (vif.o_Blank !== 1'b0) begin errors++; $display("FAIL palette_blank code %0d got %b exp 0", k, vif.o_Blank); end
        end
        vif.i_pixelState = 3'b001;
    endtask

    // Reset at scan position (300,10) for three edges, then resume.
    task automatic test_reset_mid();
        while (cyc < 8300) tick();
        rst = 1'b1;
        for (int n = 0; n < 3; n++) begin
            tick();
            checks++; if (rgb !== 12'h000) begin errors++; $display("FAIL mid_rst_rgb edge %0d got %h exp 000", n, rgb); end
            checks++; if (vif.o_Blank !== 1'b1) begin errors++; $display("FAIL mid_rst_blank edge %0d got %b exp 1", n, vif.o_Blank); end
            checks++; if (vif.o_HSync !== 1'b1) begin errors++; $display("FAIL mid_rst_hsync edge %0d got %b exp 1", n, vif.o_HSync); end
            checks++; if (vif.o_VSync !== 1'b1) begin errors++; $display("FAIL mid_rst_vsync edge %0d got %b exp 1", n, vif.o_VSync); end
            checks++; if (vif.o_FrameTick !== 1'b0) begin errors++; $display("FAIL mid_rst_tick edge %0d got %b exp 0", n, vif.o_FrameTick); end
        end
        rst = 1'b0;
        tick();
        checks++; if (vif.o_FrameTick !== 1'b1) begin errors++; $display("FAIL resume_tick got %b exp 1", vif.o_FrameTick); end
        checks++; if (vif.o_Blank !== 1'b0) begin errors++; $display("FAIL resume_blank got %b exp 0", vif.o_Blank); end
        checks++; if (rgb !== 12'hFFF) begin errors++; $display("FAIL resume_rgb got %h exp FFF", rgb); end
        tick();
        checks++; if (vif.o_FrameTick !== 1'b0) begin errors++; $display("FAIL resume_tick_end got %b exp 0", vif.o_FrameTick); end
        while (cyc < 640) tick();
        checks++; if (vif.o_Blank !== 1'b0) begin errors++; $display("FAIL resume_blank_640 got %b exp 0", vif.o_Blank); end
        tick();
        checks++; if (vif.o_Blank !== 1'b1) begin errors++; $display("FAIL resume_blank_641 got %b exp 1", vif.o_Blank); end
    endtask

    initial begin
        vif.i_pixelState   = 3'b001;
        vif_s.i_pixelState = 3'b001;
        test_reset();
        test_frame();
        test_line();
        test_palette();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
